l2_msg_flit_serializer: RTL and testbench

L2_MSG_FLIT_SERIALIZER -- requirements
Module: l2_msg_flit_serializer

---
 rtl/l2_noc_pkg.sv | 49 ++++
 rtl/l2_msg_flit_serializer_if.sv | 31 +++
 rtl/l2_msg_flit_serializer.sv | 120 ++++++++++++
 tb/tb_l2_msg_flit_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_noc_pkg.sv
// rtl/l2_noc_pkg.sv - shared NoC flit layout, payload lengths, FSM encoding and header builder
package l2_noc_pkg;

    localparam int FBITS = 64;

    localparam int HDR_CHIPID_LO = 50;
    localparam int HDR_CHIPID_W  = 14;
    localparam int HDR_X_LO      = 42;
    localparam int HDR_Y_LO      = 34;
    localparam int HDR_LEN_LO    = 22;
    localparam int HDR_TYPE_LO   = 14;
    localparam int HDR_SRC_LO    = 8;
    localparam int HDR_SRC_W     = 6;
    localparam int COORD_W       = 8;
    localparam int LEN_W         = 8;
    localparam int TYPE_W        = 8;
    localparam int ADDR_TAG_W    = 26;

    localparam logic [LEN_W-1:0] PLEN_NO_DATA   = 8'd1;
    localparam logic [LEN_W-1:0] PLEN_WITH_DATA = 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_e;

    // Header flit: routing fields on top, length/type/source below, reserved bits zero.
    function automatic logic [FBITS-1:0] make_header(
        input logic [HDR_CHIPID_W-1:0] chipid,
        input logic [COORD_W-1:0]      x,
        input logic [COORD_W-1:0]      y,
        input logic [LEN_W-1:0]        len,
        input logic [TYPE_W-1:0]       mtype,
        input logic [HDR_SRC_W-1:0]    src
    );
        logic [FBITS-1:0] h;
        h = '0;
        h[HDR_CHIPID_LO +: HDR_CHIPID_W] = chipid;
        h[HDR_X_LO      +: COORD_W]      = x;
        h[HDR_Y_LO      +: COORD_W]      = y;
        h[HDR_LEN_LO    +: LEN_W]        = len;
        h[HDR_TYPE_LO   +: TYPE_W]       = mtype;
        h[HDR_SRC_LO    +: HDR_SRC_W]    = src;
        return h;
    endfunction

endpackage

// File: rtl/l2_msg_flit_serializer_if.sv
// rtl/l2_msg_flit_serializer_if.sv - descriptor-in / flit-out bundle for the L2 message serializer
interface l2_msg_flit_serializer_if (
    input logic clk
);
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_type;
    logic [5:0]  msg_source;
    logic [25:0] msg_tag;
    logic [63:0] msg_data;
    logic        msg_has_data;
    logic [63:0] flit_data;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;
    logic [7:0]  msg_count;

    // Message producer and flit consumer side.
    modport master (
        input  clk,
        output msg_valid, msg_type, msg_source, msg_tag, msg_data, msg_has_data, flit_ready,
        input  msg_ready, flit_data, flit_valid, busy, msg_count
    );

    // Serializer side.
    modport slave (
        input  clk,
        input  msg_valid, msg_type, msg_source, msg_tag, msg_data, msg_has_data, flit_ready,
        output msg_ready, flit_data, flit_valid, busy, msg_count
    );
endinterface

// File: rtl/l2_msg_flit_serializer.sv
// rtl/l2_msg_flit_serializer.sv - turns one L2 message descriptor into header/address/data NoC flits
module l2_msg_flit_serializer
    import l2_noc_pkg::*;
#(
    parameter logic [13:0] DEST_CHIPID = 14'd0,
    parameter logic [7:0]  DEST_X      = 8'd0,
    parameter logic [7:0]  DEST_Y      = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [7:0]  msg_type,
    input  logic [5:0]  msg_source,
    input  logic [25:0] msg_tag,
    input  logic [63:0] msg_data,
    input  logic        msg_has_data,
    output logic [63:0] flit_data,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic        busy,
    output logic [7:0]  msg_count
);

    state_e      state_q,    state_d;
    logic [7:0]  type_q,     type_d;
    logic [5:0]  source_q,   source_d;
    logic [25:0] tag_q,      tag_d;
    logic [63:0] data_q,     data_d;
    logic        has_data_q, has_data_d;
    logic [7:0]  count_q,    count_d;
    logic        xfer;

    // Handshake outputs come from the state register only, never from flit_ready.
    always_comb begin
        msg_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        flit_valid = (state_q != ST_IDLE);
        xfer       = flit_valid && flit_ready;
        msg_count  = count_q;
    end

    // Flit payload is a pure function of state and the captured descriptor, so it holds under backpressure.
    always_comb begin
        flit_data = '0;
        case (state_q)
            ST_HDR:  flit_data = make_header(DEST_CHIPID, DEST_X, DEST_Y,
                                             has_data_q ? PLEN_WITH_DATA : PLEN_NO_DATA,
                                             type_q, source_q);
            ST_ADDR: flit_data = {{(FBITS-ADDR_TAG_W){1'b0}}, tag_q};
            ST_DATA: flit_data = data_q;
            default: flit_data = '0;
        endcase
    end

    // Next-state: capture on accept, advance one flit per transfer, count on the last flit.
    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        source_d   = source_q;
        tag_d      = tag_q;
        data_d     = data_q;
        has_data_d = has_data_q;
        count_d    = count_q;
        case (state_q)
            ST_IDLE: begin
                if (msg_valid) begin
                    type_d     = msg_type;
                    source_d   = msg_source;
                    tag_d      = msg_tag;
                    data_d     = msg_data;
                    has_data_d = msg_has_data;
                    state_d    = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (xfer) begin
                    if (has_data_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                        count_d = count_q + 8'd1;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and holding registers; reset drops any partial message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            type_q     <= '0;
            source_q   <= '0;
            tag_q      <= '0;
            data_q     <= '0;
            has_data_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            source_q   <= source_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            has_data_q <= has_data_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_l2_msg_flit_serializer.sv
// tb/tb_l2_msg_flit_serializer.sv - scoreboard bench for the L2 message flit serializer
module tb_l2_msg_flit_serializer;

    localparam logic [13:0] T_CHIP = 14'h2A5C;
    localparam logic [7:0]  T_X    = 8'hC3;
    localparam logic [7:0]  T_Y    = 8'h5A;

    typedef struct {
        logic [63:0] data;
        bit          last;
    } exp_flit_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l2_msg_flit_serializer_if bus (.clk(clk));

    l2_msg_flit_serializer #(
        .DEST_CHIPID(T_CHIP),
        .DEST_X     (T_X),
        .DEST_Y     (T_Y)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .msg_valid   (bus.msg_valid),
        .msg_ready   (bus.msg_ready),
        .msg_type    (bus.msg_type),
        .msg_source  (bus.msg_source),
        .msg_tag     (bus.msg_tag),
        .msg_data    (bus.msg_data),
        .msg_has_data(bus.msg_has_data),
        .flit_data   (bus.flit_data),
        .flit_valid  (bus.flit_valid),
        .flit_ready  (bus.flit_ready),
        .busy        (bus.busy),
        .msg_count   (bus.msg_count)
    );

    exp_flit_t   exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          model_cnt = 0;
    int          accepts = 0;
    bit          post_reset = 1'b0;
    bit          stall_pending = 1'b0;
    logic [63:0] stall_data = '0;
    bit          burst_mode = 1'b0;
    bit          have_last_accept = 1'b0;
    longint      cycle = 0;
    longint      last_accept = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor and reference model: a message is a list of flits queued at accept time.
    always @(negedge clk) begin
        bit        model_busy;
        exp_flit_t f;
        logic [7:0] len;
        cycle++;
        if (rst) begin
            exp_q.delete();
            model_cnt        = 0;
            stall_pending    = 1'b0;
            post_reset       = 1'b1;
            have_last_accept = 1'b0;
        end else begin
            model_busy = (exp_q.size() != 0);
            chk("busy",       {63'd0, bus.busy},       {63'd0, model_busy});
            chk("msg_ready",  {63'd0, bus.msg_ready},  {63'd0, !model_busy});
            chk("flit_valid", {63'd0, bus.flit_valid}, {63'd0, model_busy});
            chk("msg_count",  {56'd0, bus.msg_count},  64'(model_cnt));
            if (post_reset) begin
                chk("reset_flit_data", bus.flit_data, 64'd0);
                post_reset = 1'b0;
            end
            if (stall_pending && bus.flit_valid)
                chk("stall_hold", bus.flit_data, stall_data);
            stall_pending = 1'b0;
            if (bus.flit_valid && bus.flit_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_flit: got %h, expected no flit", bus.flit_data);
                end else begin
                    f = exp_q.pop_front();
                    chk("flit", bus.flit_data, f.data);
                    if (f.last) model_cnt = (model_cnt + 1) % 256;
                end
            end else if (bus.flit_valid) begin
                stall_pending = 1'b1;
                stall_data    = bus.flit_data;
            end
            if (bus.msg_valid && !model_busy) begin
                len = bus.msg_has_data ? 8'd2 : 8'd1;
                f.data = {T_CHIP, T_X, T_Y, 4'b0000, len, bus.msg_type, bus.msg_source, 8'h00};
                f.last = 1'b0;
                exp_q.push_back(f);
                f.data = {38'd0, bus.msg_tag};
                f.last = !bus.msg_has_data;
                exp_q.push_back(f);
                if (bus.msg_has_data) begin
                    f.data = bus.msg_data;
                    f.last = 1'b1;
                    exp_q.push_back(f);
                end
                if (burst_mode && have_last_accept)
                    chk("burst_gap", 64'(cycle - last_accept), 64'd3);
                last_accept      = cycle;
                have_last_accept = 1'b1;
                accepts++;
            end
        end
    end

    task automatic send(input logic [7:0] t, input logic [5:0] s, input logic [25:0] g,
                        input logic [63:0] d, input logic hd);
        bus.msg_type     = t;
        bus.msg_source   = s;
        bus.msg_tag      = g;
        bus.msg_data     = d;
        bus.msg_has_data = hd;
        bus.msg_valid    = 1'b1;
        @(posedge clk); #1;
        bus.msg_valid    = 1'b0;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            @(posedge clk); #1;
            i++;
        end
        if (i >= 500) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: got %0d flits outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic randomize_fields(input bit allow_data);
        bus.msg_type     = 8'($urandom);
        bus.msg_source   = 6'($urandom);
        bus.msg_tag      = 26'($urandom);
        bus.msg_data     = {32'($urandom), 32'($urandom)};
        bus.msg_has_data = allow_data ? 1'($urandom) : 1'b0;
    endtask

    initial begin
        int target;
        int guard;
        rst = 1'b1;
        bus.msg_valid    = 1'b0;
        bus.msg_type     = '0;
        bus.msg_source   = '0;
        bus.msg_tag      = '0;
        bus.msg_data     = '0;
        bus.msg_has_data = 1'b0;
        bus.flit_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Two-flit message without data
        @(posedge clk); #1;
        send(8'h0E, 6'd3, 26'h0ABCDEF, 64'd0, 1'b0);
        wait_idle();
        chk("count_after_first", {56'd0, bus.msg_count}, 64'd1);

        // Three-flit message with data
        send(8'h21, 6'd17, 26'h1234567, 64'hDEADBEEF_CAFEF00D, 1'b1);
        wait_idle();
        chk("count_after_data", {56'd0, bus.msg_count}, 64'd2);

        // Five-cycle stall while the address flit is presented
        send(8'h33, 6'd9, 26'h3FFFFFF, 64'd0, 1'b0);
        @(posedge clk); #1;
        bus.flit_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.flit_ready = 1'b1;
        wait_idle();
        chk("count_after_stall", {56'd0, bus.msg_count}, 64'd3);

        // Reset while the data flit is presented
        send(8'h44, 6'd1, 26'h0000F0F, 64'h0123_4567_89AB_CDEF, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pulse_reset();
        chk("rst_flit_valid", {63'd0, bus.flit_valid}, 64'd0);
        chk("rst_msg_ready",  {63'd0, bus.msg_ready},  64'd1);
        chk("rst_msg_count",  {56'd0, bus.msg_count},  64'd0);
        send(8'h55, 6'd2, 26'h0055AA5, 64'hFFFF_0000_FFFF_0000, 1'b1);
        wait_idle();
        chk("count_after_rst", {56'd0, bus.msg_count}, 64'd1);

        // 256 back-to-back messages with fields churning every cycle
        pulse_reset();
        burst_mode     = 1'b1;
        bus.flit_ready = 1'b1;
        target         = accepts + 256;
        randomize_fields(1'b0);
        bus.msg_valid  = 1'b1;
        guard          = 0;
        while (accepts < target && guard < 2000) begin
            @(posedge clk); #1;
            randomize_fields(1'b0);
            guard++;
        end
        bus.msg_valid = 1'b0;
        burst_mode    = 1'b0;
        wait_idle();
        chk("burst_accepts", 64'(accepts), 64'(target));
        chk("burst_wrap",    {56'd0, bus.msg_count}, 64'd0);

        // Random traffic with random backpressure and msg_valid held through busy periods
        for (int c = 0; c < 400; c++) begin
            randomize_fields(1'b1);
            bus.msg_valid  = ($urandom_range(0, 9) < 7);
            bus.flit_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus.msg_valid  = 1'b0;
        bus.flit_ready = 1'b1;
        wait_idle();
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
